// File: rtl/nios2_qsys_debug_mon_pkg.sv
// Shared definitions for the debug monitor access controller: FSM states,
// jdo command-word bit positions and the fixed Avalon byte-enable value.
package nios2_qsys_debug_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } mon_state_t;

    // Command word flags carried on jdo together with the ocimem_a strobe
    localparam int JDO_RD      = 35;
    localparam int JDO_AUTOINC = 34;

    // Monitor accesses are always full 32-bit words
    localparam logic [3:0] AVM_BYTEEN = 4'hF;

    // Data payload carried on jdo together with the ocimem_b strobe
    function automatic logic [31:0] jdo_wdata(input logic [37:0] jdo_word);
        return jdo_word[31:0];
    endfunction

endpackage

// File: rtl/nios2_qsys_debug_mon_timeout.sv
// Bus stall watchdog: a loadable counter of waitrequest cycles that saturates
// at TIMEOUT-1 and raises a registered terminal-count flag at that value.
// While the flag is high, the next stalled cycle is the last one allowed.
module nios2_qsys_debug_mon_timeout #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_inc,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] TC_VAL     = CNT_W'(TIMEOUT - 1);
    localparam logic             TC_AT_ZERO = (TC_VAL == {CNT_W{1'b0}});

    logic [CNT_W-1:0] r_cnt;
    logic             r_tc;
    logic [CNT_W-1:0] w_cnt_next;

    // Next count: clear on load, count stalls, hold once the terminal value is reached
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_load) begin
            w_cnt_next = {CNT_W{1'b0}};
        end else if (i_inc && (r_cnt != TC_VAL)) begin
            w_cnt_next = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    // Count register and registered terminal-count flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= {CNT_W{1'b0}};
            r_tc  <= TC_AT_ZERO;
        end else begin
            r_cnt <= w_cnt_next;
            r_tc  <= (w_cnt_next == TC_VAL);
        end
    end

    assign o_tc = r_tc;

endmodule

// File: rtl/nios2_qsys_nios2_cpu_debug_mon_ctrl.sv
// Debug monitor access controller. Converts the debug slave wrapper's
// system-clock strobes into single-word Avalon-MM master reads and writes,
// and reports the result back through MonDReg / monitor_ready / monitor_error.
module nios2_qsys_nios2_cpu_debug_mon_ctrl
    import nios2_qsys_debug_mon_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W+1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    mon_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_autoinc;
    logic [31:0]       r_mon_d;
    logic              r_ready;
    logic              r_error;
    logic              r_read;
    logic              r_write;
    logic [31:0]       r_wdata;

    logic [ADDR_W-1:0] w_cmd_addr;
    logic [ADDR_W-1:0] w_addr_inc;
    logic              w_any_strobe;
    logic              w_busy;
    logic              w_accept;
    logic              w_start;
    logic              w_stall;
    logic              w_tc;
    logic              w_unused_jdo;

    assign w_cmd_addr   = jdo[ADDR_W-1:0];
    assign w_addr_inc   = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign w_busy       = (r_state != ST_IDLE);
    assign w_accept     = (r_state == ST_IDLE) && debugack;
    assign w_stall      = w_busy && avm_waitrequest;
    // Bits 37:36 carry no meaning here; 33:32 lie above every legal address width
    assign w_unused_jdo = ^{jdo[37:36], jdo[33:32]};

    // A bus transfer is launched this cycle: mirrors the IDLE priority in the FSM
    assign w_start = w_accept &&
                     ((take_action_ocimem_a && jdo[JDO_RD]) ||
                      (!take_action_ocimem_a && take_action_ocimem_b) ||
                      (!take_action_ocimem_a && !take_action_ocimem_b &&
                       take_no_action_ocimem_a && r_autoinc));

    nios2_qsys_debug_mon_timeout #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_start),
        .i_inc  (w_stall),
        .o_tc   (w_tc)
    );

    // Monitor FSM: command decode in IDLE, one bus word per RD/WR visit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_addr    <= {ADDR_W{1'b0}};
            r_autoinc <= 1'b0;
            r_mon_d   <= 32'h0000_0000;
            r_ready   <= 1'b1;
            r_error   <= 1'b0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_wdata   <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_strobe && !debugack) begin
                        // CPU not halted: refuse everything, touch nothing else
                        r_error <= 1'b1;
                    end else if (take_action_ocimem_a) begin
                        // New command; a simultaneous data strobe is refused
                        r_addr    <= w_cmd_addr;
                        r_autoinc <= jdo[JDO_AUTOINC];
                        r_error   <= take_action_ocimem_b;
                        if (jdo[JDO_RD]) begin
                            r_state <= ST_RD;
                            r_read  <= 1'b1;
                            r_ready <= 1'b0;
                        end
                    end else if (take_action_ocimem_b) begin
                        // Write data is echoed in MonDReg for readback
                        r_wdata <= jdo_wdata(jdo);
                        r_mon_d <= jdo_wdata(jdo);
                        r_state <= ST_WR;
                        r_write <= 1'b1;
                        r_ready <= 1'b0;
                    end else if (take_no_action_ocimem_a && r_autoinc) begin
                        // Streaming read: advance first, then fetch
                        r_addr  <= w_addr_inc;
                        r_state <= ST_RD;
                        r_read  <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end
                ST_RD: begin
                    if (w_any_strobe) begin
                        r_error <= 1'b1;
                    end
                    if (!avm_waitrequest) begin
                        r_mon_d <= avm_readdata;
                        r_read  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (w_tc) begin
                        r_read  <= 1'b0;
                        r_ready <= 1'b1;
                        r_error <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    if (w_any_strobe) begin
                        r_error <= 1'b1;
                    end
                    if (!avm_waitrequest) begin
                        if (r_autoinc) begin
                            r_addr <= w_addr_inc;
                        end
                        r_write <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (w_tc) begin
                        r_write <= 1'b0;
                        r_ready <= 1'b1;
                        r_error <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign MonDReg        = r_mon_d;
    assign monitor_ready  = r_ready;
    assign monitor_error  = r_error;
    assign avm_address    = {r_addr, 2'b00};
    assign avm_read       = r_read;
    assign avm_write      = r_write;
    assign avm_writedata  = r_wdata;
    assign avm_byteenable = AVM_BYTEEN;

endmodule
